cache_traffic_checker: RTL and testbench

Synthesisable, parametrised CPU-side traffic generator and self-checker for the cache subsystem. It replaces the free-running processor stimulus and the waveform inspection of state, address, hit, ready and data. It drives write-then-read sweeps into the cache request port and compares every read against an address-derived pattern. It also counts hits, misses and errors, and raises a pass/fail verdict usable on silicon or in simulation.

---
 rtl/cache_traffic_checker_if.sv | 28 ++
 rtl/cache_traffic_checker.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cache_traffic_checker.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_traffic_checker_if.sv
// cache_traffic_checker_if
//   CPU-side request/response bundle between the traffic checker and the
//   cache under test.
//   master  : request driver (checker) - drives cpu_req/cpu_we/cpu_addr/cpu_wdata,
//             observes cache_rdy/cache_hit/cache_rdata.
//   slave   : cache side - the reverse directions.
interface cache_traffic_checker_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cache_rdy;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cache_rdy, cache_hit, cache_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cache_rdy, cache_hit, cache_rdata
  );
endinterface

// File: rtl/cache_traffic_checker.sv
// cache_traffic_checker
//   CPU-side traffic generator and self-checker for the cache subsystem.
//   One run = a write sweep of NUM_TXN addresses (BASE + i*STRIDE, wrapping
//   mod 2^ADDR_W) with data PATTERN ^ addr, then a read sweep comparing each
//   returned word against the same pattern. Hits, misses and errors are
//   counted (saturating); a per-request TIMEOUT aborts the run.
//   Optional feature macro: CACHE_CHECKER_REREAD_EN adds a third (reread)
//   sweep after the read sweep.
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle run trigger (ignored while busy)
//   bus        : master side of cache_traffic_checker_if
//   busy       : run in progress
//   done       : sticky, run finished
//   pass       : valid with done; no errors and no timeout
//   timeout    : sticky, a request went TIMEOUT cycles without cache_rdy
//   err_count, hit_count, miss_count : 16-bit saturating counters
module cache_traffic_checker #(
  parameter int                 ADDR_W  = 8,
  parameter int                 DATA_W  = 32,
  parameter int                 NUM_TXN = 16,
  parameter int                 BASE    = 0,
  parameter int                 STRIDE  = 4,
  parameter logic [DATA_W-1:0]  PATTERN = 32'hA5A5_0000,
  parameter int                 TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  cache_traffic_checker_if.master       bus,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [15:0]                   err_count,
  output logic [15:0]                   hit_count,
  output logic [15:0]                   miss_count
);

  localparam int                IDX_W     = $clog2(NUM_TXN + 1);
  localparam int                TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TXN - 1);
  localparam logic [TMO_W-1:0]  LAST_WAIT = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);

  typedef enum logic [3:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
`ifdef CACHE_CHECKER_REREAD_EN
    RR_REQ,
    RR_WAIT,
`endif
    GAP,
    DONE
  } state_t;

  // Which sweep the shared GAP state returns to.
  typedef enum logic [1:0] {
    M_WR,
    M_RD,
    M_RR
  } mode_t;

  state_t            r_state;
  state_t            w_next;
  state_t            w_hold;
  mode_t             r_mode;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [TMO_W-1:0]  r_wait;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [15:0]       r_err;
  logic [15:0]       r_hit;
  logic [15:0]       r_miss;

  logic              w_req;
  logic              w_we;
  logic              w_launch;
  logic              w_complete;
  logic              w_tmo;
  logic              w_advance;
  logic              w_finish;
  logic              w_last;
  logic              w_mismatch;
  logic [DATA_W-1:0] w_expect;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_last     = (r_idx == LAST_IDX);
  assign w_expect   = PATTERN ^ DATA_W'(r_addr);
  assign w_mismatch = (bus.cache_rdata != w_expect);

  // Request outputs decode from the state so that an asynchronous reset
  // drops cpu_req in the same instant.
  assign bus.cpu_req   = w_req;
  assign bus.cpu_we    = w_we;
  assign bus.cpu_addr  = w_req ? r_addr : '0;
  assign bus.cpu_wdata = (w_req && w_we) ? w_expect : '0;

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign timeout    = r_timeout;
  assign err_count  = r_err;
  assign hit_count  = r_hit;
  assign miss_count = r_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_hold     = r_state;
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_launch   = 1'b0;
    w_complete = 1'b0;
    w_tmo      = 1'b0;
    w_advance  = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_launch = 1'b1;
          w_next   = WR_REQ;
        end
      end
      WR_REQ, WR_WAIT: begin
        w_req  = 1'b1;
        w_we   = 1'b1;
        w_hold = WR_WAIT;
      end
      RD_REQ, RD_WAIT: begin
        w_req  = 1'b1;
        w_hold = RD_WAIT;
      end
`ifdef CACHE_CHECKER_REREAD_EN
      RR_REQ, RR_WAIT: begin
        w_req  = 1'b1;
        w_hold = RR_WAIT;
      end
`endif
      GAP: begin
        w_advance = 1'b1;
        case (r_mode)
          M_WR: w_next = w_last ? RD_REQ : WR_REQ;
`ifdef CACHE_CHECKER_REREAD_EN
          M_RD: w_next = w_last ? RR_REQ : RD_REQ;
          default: begin
            if (w_last) begin
              w_finish = 1'b1;
              w_next   = DONE;
            end else begin
              w_next = RR_REQ;
            end
          end
`else
          default: begin
            if (w_last) begin
              w_finish = 1'b1;
              w_next   = DONE;
            end else begin
              w_next = RD_REQ;
            end
          end
`endif
        endcase
      end
      default: w_next = IDLE;
    endcase

    // Shared completion / timeout handling for every request state; a
    // cache_rdy seen in the REQ cycle itself completes the request.
    if (w_req) begin
      if (bus.cache_rdy) begin
        w_complete = 1'b1;
        w_next     = GAP;
      end else if (r_wait == LAST_WAIT) begin
        w_tmo    = 1'b1;
        w_finish = 1'b1;
        w_next   = DONE;
      end else begin
        w_next = w_hold;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= M_WR;
      r_idx     <= '0;
      r_addr    <= '0;
      r_wait    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= '0;
      r_hit     <= '0;
      r_miss    <= '0;
    end else begin
      if (w_launch) begin
        r_mode    <= M_WR;
        r_idx     <= '0;
        r_addr    <= BASE_A;
        r_wait    <= '0;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
        r_err     <= '0;
        r_hit     <= '0;
        r_miss    <= '0;
      end

      if (w_req) begin
        r_wait <= w_complete ? '0 : r_wait + 1'b1;
      end

      if (w_complete) begin
        if (bus.cache_hit) begin
          r_hit <= sat_inc(r_hit);
        end else begin
          r_miss <= sat_inc(r_miss);
        end
        if (r_mode != M_WR && w_mismatch) begin
          r_err <= sat_inc(r_err);
        end
      end

      if (w_tmo) begin
        r_timeout <= 1'b1;
        r_err     <= sat_inc(r_err);
      end

      if (w_advance) begin
        if (w_last) begin
          r_idx  <= '0;
          r_addr <= BASE_A;
          r_mode <= (r_mode == M_WR) ? M_RD : M_RR;
        end else begin
          r_idx  <= r_idx + 1'b1;
          r_addr <= r_addr + STRIDE_A;
        end
      end

      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= !w_tmo && !r_timeout && (r_err == 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_cache_traffic_checker.sv
module tb_cache_traffic_checker;

`ifdef CACHE_CHECKER_REREAD_EN
  localparam int NP = 3;
`else
  localparam int NP = 2;
`endif
  localparam int TO  = 64;
  localparam int BUD = 2000;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: BASE 0x10, STRIDE 4, NUM_TXN 4, TIMEOUT 64
  cache_traffic_checker_if #(.ADDR_W(8), .DATA_W(32)) busA ();
  logic        startA, busyA, doneA, passA, tmoA;
  logic [15:0] errA, hitA, missA;

  cache_traffic_checker #(
    .ADDR_W(8), .DATA_W(32), .NUM_TXN(4), .BASE(8'h10), .STRIDE(4),
    .PATTERN(32'hA5A5_0000), .TIMEOUT(TO)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .bus(busA),
    .busy(busyA), .done(doneA), .pass(passA), .timeout(tmoA),
    .err_count(errA), .hit_count(hitA), .miss_count(missA)
  );

  // Responder A: registered (lat cycles) or combinational, with a small
  // memory; valid bits are tagged with an epoch so a new epoch = empty cache.
  logic        a_comb, a_never;
  int          a_lat;
  logic [7:0]  a_faddr;
  logic [31:0] a_fmask;
  int          epoch;
  bit   [31:0] memA [256];
  int          vepA [256];
  logic        ra_rdy, ra_hit;
  logic [31:0] ra_rdata;
  int          ra_cnt;
  logic [7:0]  qa_addr [$];
  logic [31:0] qa_data [$];

  function automatic logic [31:0] flipA(input logic [7:0] a);
    return (a == a_faddr) ? a_fmask : 32'h0;
  endfunction

  assign busA.cache_rdy   = a_comb ? busA.cpu_req : ra_rdy;
  assign busA.cache_hit   = a_comb ? (vepA[busA.cpu_addr] == epoch) : ra_hit;
  assign busA.cache_rdata = a_comb ? (memA[busA.cpu_addr] ^ flipA(busA.cpu_addr)) : ra_rdata;

  always @(posedge clk) begin
    ra_rdy <= 1'b0;
    if (a_comb) begin
      if (busA.cpu_req && busA.cpu_we) begin
        memA[busA.cpu_addr] <= busA.cpu_wdata;
        vepA[busA.cpu_addr] <= epoch;
        qa_addr.push_back(busA.cpu_addr);
        qa_data.push_back(busA.cpu_wdata);
      end
    end else if (busA.cpu_req && !ra_rdy) begin
      if (!a_never && ra_cnt >= a_lat - 1) begin
        ra_rdy   <= 1'b1;
        ra_cnt   <= 0;
        ra_hit   <= (vepA[busA.cpu_addr] == epoch);
        ra_rdata <= memA[busA.cpu_addr] ^ flipA(busA.cpu_addr);
        if (busA.cpu_we) begin
          memA[busA.cpu_addr] <= busA.cpu_wdata;
          vepA[busA.cpu_addr] <= epoch;
          qa_addr.push_back(busA.cpu_addr);
          qa_data.push_back(busA.cpu_wdata);
        end
      end else begin
        ra_cnt <= ra_cnt + 1;
      end
    end else if (!busA.cpu_req) begin
      ra_cnt <= 0;
    end
  end

  // ---------------- DUT B: wrap case BASE 0xFC, STRIDE 4, NUM_TXN 3
  cache_traffic_checker_if #(.ADDR_W(8), .DATA_W(32)) busB ();
  logic        startB, busyB, doneB, passB, tmoB;
  logic [15:0] errB, hitB, missB;

  cache_traffic_checker #(
    .ADDR_W(8), .DATA_W(32), .NUM_TXN(3), .BASE(8'hFC), .STRIDE(4),
    .PATTERN(32'hA5A5_0000), .TIMEOUT(256)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .bus(busB),
    .busy(busyB), .done(doneB), .pass(passB), .timeout(tmoB),
    .err_count(errB), .hit_count(hitB), .miss_count(missB)
  );

  bit   [31:0] memB [256];
  logic        rb_rdy;
  logic [31:0] rb_rdata;
  logic [7:0]  qb_addr [$];
  logic [31:0] qb_data [$];

  assign busB.cache_rdy   = rb_rdy;
  assign busB.cache_hit   = 1'b0;
  assign busB.cache_rdata = rb_rdata;

  always @(posedge clk) begin
    rb_rdy <= 1'b0;
    if (busB.cpu_req && !rb_rdy) begin
      rb_rdy   <= 1'b1;
      rb_rdata <= memB[busB.cpu_addr];
      if (busB.cpu_we) begin
        memB[busB.cpu_addr] <= busB.cpu_wdata;
        qb_addr.push_back(busB.cpu_addr);
        qb_data.push_back(busB.cpu_wdata);
      end
    end
  end

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Pulse startA; cyc = cycles from the start-sampling edge until done
  // (first request cycle = 1), bounded by BUD.
  task automatic runA(input int pulse_at, output int cyc);
    cyc = 0;
    @(negedge clk); startA = 1'b1;
    do begin
      @(negedge clk);
      startA = (pulse_at > 0 && cyc + 1 == pulse_at);
      cyc++;
    end while (!doneA && cyc < BUD);
    startA = 1'b0;
  endtask

  typedef struct {
    bit          comb;
    bit          never;
    int          lat;
    bit          fresh;
    logic [7:0]  faddr;
    logic [31:0] fmask;
    int          cyc;
    bit          pass;
    bit          tmo;
    int          err;
    int          hit;
    int          miss;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc;
    int guard;
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; startA = 1'b0; startB = 1'b0;
    a_comb = 1'b0; a_never = 1'b0; a_lat = 1; a_faddr = 8'h00; a_fmask = 32'h0;
    epoch = 1;

    //            comb never lat fresh faddr  fmask          cyc            pass tmo err   hit         miss
    vecs[0] = '{1'b0, 1'b0, 1, 1'b1, 8'h00, 32'h0,        NP*4*3+1,      1'b1, 1'b0, 0,    4*(NP-1),   4};
    vecs[1] = '{1'b0, 1'b0, 1, 1'b1, 8'h14, 32'h1,        NP*4*3+1,      1'b0, 1'b0, NP-1, 4*(NP-1),   4};
    vecs[2] = '{1'b0, 1'b0, 3, 1'b1, 8'h1C, 32'h8000_0000, NP*4*5+1,     1'b0, 1'b0, NP-1, 4*(NP-1),   4};
    vecs[3] = '{1'b0, 1'b0, 1, 1'b0, 8'h00, 32'h0,        NP*4*3+1,      1'b1, 1'b0, 0,    4*NP,       0};
    vecs[4] = '{1'b1, 1'b0, 1, 1'b1, 8'h00, 32'h0,        NP*4*2+1,      1'b1, 1'b0, 0,    4*(NP-1),   4};
    vecs[5] = '{1'b0, 1'b1, 1, 1'b1, 8'h00, 32'h0,        TO+1,          1'b0, 1'b1, 1,    0,          0};
    vecs[6] = '{1'b1, 1'b0, 1, 1'b1, 8'h10, 32'hFFFF_0000, NP*4*2+1,     1'b0, 1'b0, NP-1, 4*(NP-1),   4};

    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'h0, busyA}, 32'h0);
    chk("rst_done",  {31'h0, doneA}, 32'h0);
    chk("rst_pass",  {31'h0, passA}, 32'h0);
    chk("rst_tmo",   {31'h0, tmoA},  32'h0);
    chk("rst_cnt",   {errA, hitA | missA}, 32'h0);
    chk("rst_req",   {30'h0, busA.cpu_req, busA.cpu_we}, 32'h0);
    chk("rst_addr",  {24'h0, busA.cpu_addr}, 32'h0);
    chk("rst_wdata", busA.cpu_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- table-driven runs on DUT A
    for (int i = 0; i < 7; i++) begin
      a_comb = vecs[i].comb; a_never = vecs[i].never; a_lat = vecs[i].lat;
      a_faddr = vecs[i].faddr; a_fmask = vecs[i].fmask;
      if (vecs[i].fresh) epoch++;
      qa_addr.delete(); qa_data.delete();
      runA(0, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_done", i), {31'h0, doneA}, 32'h1);
      chk($sformatf("v%0d_busy", i), {31'h0, busyA}, 32'h0);
      chk($sformatf("v%0d_req", i), {31'h0, busA.cpu_req}, 32'h0);
      chk($sformatf("v%0d_pass", i), {31'h0, passA}, {31'h0, vecs[i].pass});
      chk($sformatf("v%0d_tmo", i), {31'h0, tmoA}, {31'h0, vecs[i].tmo});
      chk($sformatf("v%0d_err", i), {16'h0, errA}, vecs[i].err);
      chk($sformatf("v%0d_hit", i), {16'h0, hitA}, vecs[i].hit);
      chk($sformatf("v%0d_miss", i), {16'h0, missA}, vecs[i].miss);
      if (i == 0) begin
        chk("sweep_nwr", qa_addr.size(), 4);
        for (int k = 0; k < 4 && k < qa_addr.size(); k++) begin
          chk($sformatf("sweep_addr%0d", k), {24'h0, qa_addr[k]}, 32'h10 + 4*k);
          chk($sformatf("sweep_data%0d", k), qa_data[k], 32'hA5A5_0010 + 4*k);
        end
      end
      @(negedge clk);
    end

    // ---- start pulse while busy is ignored
    a_comb = 1'b0; a_never = 1'b0; a_lat = 1; a_fmask = 32'h0; epoch++;
    runA(5, cyc);
    chk("busystart_cycles", cyc, NP*4*3+1);
    chk("busystart_pass", {31'h0, passA}, 32'h1);
    chk("busystart_miss", {16'h0, missA}, 32'd4);

    // ---- reset during RD_WAIT
    a_lat = 3; epoch++;
    @(negedge clk); startA = 1'b1;
    @(negedge clk); startA = 1'b0;
    guard = 0;
    while (!(busA.cpu_req && !busA.cpu_we) && guard < BUD) begin
      @(negedge clk); guard++;
    end
    chk("rdwait_reached", {31'h0, busA.cpu_req & ~busA.cpu_we}, 32'h1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_req",  {31'h0, busA.cpu_req}, 32'h0);
    chk("arst_addr", {24'h0, busA.cpu_addr}, 32'h0);
    chk("arst_busy", {31'h0, busyA}, 32'h0);
    chk("arst_cnt",  {errA, hitA | missA}, 32'h0);
    chk("arst_done", {30'h0, doneA, passA}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    a_lat = 1; epoch++;
    runA(0, cyc);
    chk("post_rst_cycles", cyc, NP*4*3+1);
    chk("post_rst_pass", {31'h0, passA}, 32'h1);
    chk("post_rst_err", {16'h0, errA}, 32'h0);
    chk("post_rst_hitmiss", {16'h0, hitA + missA}, 4*NP);

    // ---- address wrap on DUT B
    qb_addr.delete(); qb_data.delete();
    cyc = 0;
    @(negedge clk); startB = 1'b1;
    do begin @(negedge clk); startB = 1'b0; cyc++; end while (!doneB && cyc < BUD);
    chk("wrap_cycles", cyc, NP*3*3+1);
    chk("wrap_pass", {31'h0, passB}, 32'h1);
    chk("wrap_err", {16'h0, errB}, 32'h0);
    chk("wrap_miss", {16'h0, missB}, 3*NP);
    chk("wrap_nwr", qb_addr.size(), 3);
    if (qb_addr.size() == 3) begin
      chk("wrap_a0", {24'h0, qb_addr[0]}, 32'hFC);
      chk("wrap_a1", {24'h0, qb_addr[1]}, 32'h00);
      chk("wrap_a2", {24'h0, qb_addr[2]}, 32'h04);
      chk("wrap_d0", qb_data[0], 32'hA5A5_00FC);
      chk("wrap_d1", qb_data[1], 32'hA5A5_0000);
      chk("wrap_d2", qb_data[2], 32'hA5A5_0004);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
